// File: rtl/primofact_pkg.sv
// Shared types for the prime factoriser: FSM state encoding.
package primofact_pkg;

   typedef enum logic [3:0] {
      StIdle     = 4'd0,
      StCheck    = 4'd1,
      StDivStart = 4'd2,
      StDivWait  = 4'd3,
      StEmit     = 4'd4,
      StEmitLast = 4'd5,
      StDone     = 4'd6,
      StError    = 4'd7
   } state_e;

endpackage

// File: rtl/primofact_divqr.sv
// Restoring divider producing quotient and remainder, one quotient bit per cycle.
module primofact_divqr #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             go_i,
   input  logic [WIDTH-1:0] num_i,
   input  logic [WIDTH-1:0] den_i,
   output logic             ready_o,
   output logic             error_o,
   output logic [WIDTH-1:0] quot_o,
   output logic [WIDTH-1:0] rem_o
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);

   logic [CntW-1:0]  cnt_q;
   logic             ready_q;
   logic             error_q;
   logic [WIDTH-1:0] den_q;
   logic [WIDTH-1:0] quot_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] trial;

   // Partial remainder is always < den, so the shifted value needs only one extra bit.
   always_comb begin
      shifted = {rem_q, quot_q[WIDTH-1]};
      trial   = shifted[WIDTH-1:0] - den_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ready_q <= 1'b1;
         error_q <= 1'b0;
         cnt_q   <= '0;
         den_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
      end else if (ready_q) begin
         if (go_i) begin
            ready_q <= 1'b0;
            error_q <= (den_i == '0);
            den_q   <= den_i;
            quot_q  <= num_i;
            rem_q   <= '0;
            cnt_q   <= CntW'(WIDTH);
         end
      end else if (cnt_q != '0) begin
         if (shifted >= {1'b0, den_q}) begin
            rem_q  <= trial;
            quot_q <= {quot_q[WIDTH-2:0], 1'b1};
         end else begin
            rem_q  <= shifted[WIDTH-1:0];
            quot_q <= {quot_q[WIDTH-2:0], 1'b0};
         end
         cnt_q <= cnt_q - 1'b1;
      end else begin
         ready_q <= 1'b1;
      end
   end

   assign ready_o = ready_q;
   assign error_o = error_q;
   assign quot_o  = quot_q;
   assign rem_o   = rem_q;

endmodule

// File: rtl/primofact.sv
// Prime factoriser: emits the prime factors of a number in non-decreasing order
// using trial division by 2 then odd divisors, with a valid/ack output handshake.
module primofact
   import primofact_pkg::*;
#(
   parameter  int unsigned WIDTH_LOG = 4,
   localparam int unsigned WIDTH     = 1 << WIDTH_LOG
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             go_i,
   input  logic [WIDTH-1:0] num_i,
   input  logic             ack_i,
   output logic             ready_o,
   output logic             error_o,
   output logic             valid_o,
   output logic [WIDTH-1:0] factor_o
);

   localparam logic [WIDTH-1:0] One     = WIDTH'(1);
   localparam logic [WIDTH-1:0] Two     = WIDTH'(2);
   localparam logic [WIDTH-1:0] Three   = WIDTH'(3);
   localparam logic [WIDTH-1:0] DivMax  = WIDTH'((1 << (WIDTH / 2)) + 1);
   localparam logic [WIDTH+1:0] DsqFour = (WIDTH+2)'(4);
   localparam logic [WIDTH+1:0] DsqNine = (WIDTH+2)'(9);

   state_e           state_q;
   logic [WIDTH-1:0] n_q;
   logic [WIDTH-1:0] div_q;
   logic [WIDTH+1:0] dsq_q;
   logic [WIDTH-1:0] factor_q;
   logic             ready_q;
   logic             error_q;
   logic             valid_q;
   logic             div_go_q;

   logic             dv_ready;
   logic             dv_error;
   logic [WIDTH-1:0] dv_quot;
   logic [WIDTH-1:0] dv_rem;

   primofact_divqr #(
      .WIDTH (WIDTH)
   ) u_divqr (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .go_i    (div_go_q),
      .num_i   (n_q),
      .den_i   (div_q),
      .ready_o (dv_ready),
      .error_o (dv_error),
      .quot_o  (dv_quot),
      .rem_o   (dv_rem)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         n_q      <= '0;
         div_q    <= Two;
         dsq_q    <= DsqFour;
         factor_q <= '0;
         ready_q  <= 1'b1;
         error_q  <= 1'b0;
         valid_q  <= 1'b0;
         div_go_q <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (go_i) begin
                  n_q     <= num_i;
                  div_q   <= Two;
                  dsq_q   <= DsqFour;
                  error_q <= (num_i == '0);
                  if (num_i != '0 && num_i != One) begin
                     ready_q <= 1'b0;
                     state_q <= StCheck;
                  end
               end
            end
            StCheck: begin
               if (n_q == One) begin
                  state_q <= StDone;
               end else if (dsq_q > {2'b00, n_q}) begin
                  // No divisor up to sqrt(n) remains, so n itself is prime.
                  factor_q <= n_q;
                  valid_q  <= 1'b1;
                  state_q  <= StEmitLast;
               end else begin
                  div_go_q <= 1'b1;
                  state_q  <= StDivStart;
               end
            end
            StDivStart: begin
               div_go_q <= 1'b0;
               state_q  <= StDivWait;
            end
            StDivWait: begin
               if (dv_ready) begin
                  if (dv_error) begin
                     state_q <= StError;
                  end else if (dv_rem == '0) begin
                     n_q      <= dv_quot;
                     factor_q <= div_q;
                     valid_q  <= 1'b1;
                     state_q  <= StEmit;
                  end else begin
                     if (div_q == Two) begin
                        div_q <= Three;
                        dsq_q <= DsqNine;
                     end else begin
                        // (d+2)^2 = d^2 + 4d + 4
                        div_q <= div_q + Two;
                        dsq_q <= dsq_q + {div_q, 2'b00} + DsqFour;
                     end
                     state_q <= StCheck;
                  end
               end
            end
            StEmit: begin
               if (ack_i) begin
                  valid_q <= 1'b0;
                  state_q <= StCheck;
               end
            end
            StEmitLast: begin
               if (ack_i) begin
                  valid_q <= 1'b0;
                  state_q <= StDone;
               end
            end
            StDone: begin
               ready_q <= 1'b1;
               state_q <= StIdle;
            end
            StError: begin
               ready_q <= 1'b1;
               error_q <= 1'b1;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign ready_o  = ready_q;
   assign error_o  = error_q;
   assign valid_o  = valid_q;
   assign factor_o = factor_q;

`ifndef SYNTHESIS
   a_no_x_ctrl: assert property (@(posedge clk_i) !$isunknown({clk_i, rst_i}));
   a_div_bound: assert property (@(posedge clk_i) disable iff (rst_i) div_q <= DivMax);
   a_valid_not_ready: assert property (@(posedge clk_i) disable iff (rst_i)
      !(valid_q && ready_q));
   a_valid_factor: assert property (@(posedge clk_i) disable iff (rst_i)
      valid_q |-> (factor_q >= Two && (factor_q[0] || factor_q == Two)));
`endif

endmodule

// File: tb/tb_primofact.sv
// Self-checking bench for primofact against a trial-division reference model.
module tb_primofact;

   localparam int Budget = 20000;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        go_i  = 1'b0;
   logic [15:0] num_i = '0;
   logic        ack_i = 1'b0;
   logic        ready_o;
   logic        error_o;
   logic        valid_o;
   logic [15:0] factor_o;

   int errors = 0;
   int checks = 0;

   logic [15:0] got_q[$];
   int unsigned exp_q[$];
   bit          timed_out;
   int          hold_seen;
   int          hold_unstable;

   always #5 clk_i = ~clk_i;

   primofact #(
      .WIDTH_LOG (4)
   ) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .go_i     (go_i),
      .num_i    (num_i),
      .ack_i    (ack_i),
      .ready_o  (ready_o),
      .error_o  (error_o),
      .valid_o  (valid_o),
      .factor_o (factor_o)
   );

   function automatic void ref_factor(input int unsigned n_in);
      int unsigned n = n_in;
      int unsigned d = 2;
      exp_q.delete();
      while (d * d <= n) begin
         while (n % d == 0) begin
            exp_q.push_back(d);
            n = n / d;
         end
         d = (d == 2) ? 3 : d + 2;
      end
      if (n > 1) exp_q.push_back(n);
   endfunction

   function automatic string got_str();
      string s = "";
      foreach (got_q[i]) s = {s, $sformatf("%0d ", got_q[i])};
      return s;
   endfunction

   function automatic string exp_str();
      string s = "";
      foreach (exp_q[i]) s = {s, $sformatf("%0d ", exp_q[i])};
      return s;
   endfunction

   // Runs one job from the negedge; hold>0 stalls ack on the first factor, poke retries go mid-job.
   task automatic run_job(input logic [15:0] n, input int hold, input bit poke);
      int          cyc  = 0;
      int          held = 0;
      logic [15:0] f0   = '0;
      got_q.delete();
      timed_out     = 1'b0;
      hold_seen     = 0;
      hold_unstable = 0;
      go_i  = 1'b1;
      num_i = n;
      ack_i = (hold == 0);
      @(negedge clk_i);
      go_i = 1'b0;
      while (!ready_o && cyc < Budget) begin
         if (poke && cyc == 3) begin
            go_i  = 1'b1;
            num_i = 16'd7;
         end else begin
            go_i = 1'b0;
         end
         if (valid_o) begin
            if (!ack_i) begin
               if (held == 0) f0 = factor_o;
               else if (factor_o !== f0) hold_unstable++;
               held++;
               hold_seen = held;
               if (held == hold) begin
                  ack_i = 1'b1;
                  got_q.push_back(factor_o);
               end
            end else begin
               got_q.push_back(factor_o);
            end
         end
         @(negedge clk_i);
         cyc++;
      end
      go_i = 1'b0;
      if (cyc >= Budget) timed_out = 1'b1;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if ({ready_o, error_o, valid_o} !== 3'b100)
         $display("FAIL reset_flags: got r/e/v=%b required 100", {ready_o, error_o, valid_o});
      checks++;
      if (factor_o !== 16'd0)
         $display("FAIL reset_factor: got %0d required 0", factor_o);
      if ({ready_o, error_o, valid_o} !== 3'b100 || factor_o !== 16'd0) errors++;
   endtask

   task automatic test_basic();
      run_job(16'd12, 0, 1'b0);
      ref_factor(12);
      checks++;
      if (timed_out || got_str() != exp_str() || error_o !== 1'b0) begin
         errors++;
         $display("FAIL basic_12: got '%s' err=%b timeout=%0d required '%s' err=0",
                  got_str(), error_o, timed_out, exp_str());
      end
   endtask

   task automatic test_wide();
      logic [15:0] nums[2] = '{16'd65535, 16'd65521};
      foreach (nums[k]) begin
         run_job(nums[k], 0, 1'b0);
         ref_factor(nums[k]);
         checks++;
         if (timed_out || got_str() != exp_str() || error_o !== 1'b0) begin
            errors++;
            $display("FAIL wide_%0d: got '%s' err=%b required '%s' err=0",
                     nums[k], got_str(), error_o, exp_str());
         end
      end
   endtask

   task automatic test_zero_one();
      go_i  = 1'b1;
      num_i = 16'd0;
      @(negedge clk_i);
      go_i = 1'b0;
      checks++;
      if ({ready_o, error_o, valid_o} !== 3'b110) begin
         errors++;
         $display("FAIL zero_error: got r/e/v=%b required 110", {ready_o, error_o, valid_o});
      end
      run_job(16'd1, 0, 1'b0);
      checks++;
      if (got_q.size() != 0 || error_o !== 1'b0 || ready_o !== 1'b1) begin
         errors++;
         $display("FAIL one_empty: got %0d factors err=%b ready=%b required 0 factors err=0 ready=1",
                  got_q.size(), error_o, ready_o);
      end
   endtask

   task automatic test_backpressure();
      int extra_valid = 0;
      run_job(16'd8, 10, 1'b0);
      ref_factor(8);
      checks++;
      if (timed_out || got_str() != exp_str()) begin
         errors++;
         $display("FAIL bp_factors: got '%s' required '%s'", got_str(), exp_str());
      end
      checks++;
      if (hold_seen != 10 || hold_unstable != 0) begin
         errors++;
         $display("FAIL bp_hold: got held=%0d unstable=%0d required held=10 unstable=0",
                  hold_seen, hold_unstable);
      end
      for (int i = 0; i < 8; i++) begin
         ack_i = i[0];
         @(negedge clk_i);
         if (valid_o || !ready_o) extra_valid++;
      end
      checks++;
      if (extra_valid != 0) begin
         errors++;
         $display("FAIL bp_idle_ack: got %0d bad idle cycles required 0", extra_valid);
      end
   endtask

   task automatic test_go_ignored();
      run_job(16'd12, 0, 1'b1);
      ref_factor(12);
      checks++;
      if (timed_out || got_str() != exp_str() || error_o !== 1'b0) begin
         errors++;
         $display("FAIL go_ignored: got '%s' required '%s'", got_str(), exp_str());
      end
   endtask

   task automatic test_reset_midjob();
      int stray = 0;
      go_i  = 1'b1;
      num_i = 16'd91;
      ack_i = 1'b1;
      @(negedge clk_i);
      go_i = 1'b0;
      repeat (7) @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      checks++;
      if ({ready_o, error_o, valid_o} !== 3'b100) begin
         errors++;
         $display("FAIL midjob_reset: got r/e/v=%b required 100", {ready_o, error_o, valid_o});
      end
      repeat (30) begin
         @(negedge clk_i);
         if (valid_o) stray++;
      end
      checks++;
      if (stray != 0) begin
         errors++;
         $display("FAIL midjob_stray: got %0d valid cycles required 0", stray);
      end
      run_job(16'd91, 0, 1'b0);
      ref_factor(91);
      checks++;
      if (timed_out || got_str() != exp_str()) begin
         errors++;
         $display("FAIL midjob_rerun: got '%s' required '%s'", got_str(), exp_str());
      end
   endtask

   task automatic test_random();
      logic [15:0] n;
      for (int i = 0; i < 10; i++) begin
         n = (i < 5) ? 16'($urandom_range(2000, 2)) : 16'($urandom_range(65535, 2));
         run_job(n, 0, 1'b0);
         ref_factor(n);
         checks++;
         if (timed_out || got_str() != exp_str() || error_o !== 1'b0) begin
            errors++;
            $display("FAIL random_%0d: got '%s' err=%b required '%s' err=0",
                     n, got_str(), error_o, exp_str());
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wide();
      test_zero_one();
      test_backpressure();
      test_go_ignored();
      test_reset_midjob();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
